alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
Two-requester round-robin scheduler that shares one combinational ALU (cs/x1/x2/funct7/funct3 → out/zero) between requesters, e.g. the execute stage and a secondary address/branch-compare unit. It accepts one operation at a time through a valid/ready handshake and registers the operands before driving the ALU. It then captures out/zero and returns them to the granting requester through a held response handshake.

Parameters:
WIDTH, 32, operand/result width (matches ALU x1/x2/out)
CNT_W, 16, width of completed-operation counter

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
rN_valid  in  1  requester N (N=0,1) has an operation
rN_ready  out  1  arbiter accepts requester N's operation this cycle
rN_cs  in  3  ALU control signal from requester N
rN_x1, rN_x2  in  WIDTH  operands from requester N (signed)
rN_funct7  in  7  funct7 from requester N
rN_funct3  in  3  funct3 from requester N
rN_rsp_valid  out  1  result for requester N available
rN_rsp_ready  in  1  requester N consumes result
rN_rsp_data  out  WIDTH  result for requester N
rN_rsp_zero  out  1  zero flag for requester N
alu_cs  out  3  to ALU cs
alu_x1, alu_x2  out  WIDTH  to ALU operands
alu_funct7  out  7  to ALU funct7
alu_funct3  out  3  to ALU funct3
alu_out  in  WIDTH  from ALU out
alu_zero  in  1  from ALU zero
busy  out  1  high in any state other than IDLE
op_count  out  CNT_W  completed operations (response handshakes)

Behaviour:
- Reset (async on rst_n low; release synchronous to clk): state=IDLE; last_grant=1, so requester 0 wins the first tie; operand regs, alu_* outputs, result regs, op_count all 0; rN_ready=0; rN_rsp_valid=0; busy=0.
- FSM states: IDLE → EXEC → RESP → IDLE.
- IDLE: winner = the only valid requester; if both valid, the one ≠ last_grant. rN_ready is combinational and high only for the winner, and only in IDLE. When rN_valid && rN_ready: latch cs/x1/x2/funct7/funct3 and grant id; last_grant := N; go EXEC. No valid requester → stay IDLE.
- EXEC (exactly 1 cycle): alu_* driven from operand registers, which are stable the whole cycle. At the clock edge, capture alu_out/alu_zero into result regs; go RESP.
- RESP: rG_rsp_valid=1 for the granted requester G only; rsp_data/rsp_zero come from result regs and hold stable until handshake. On rG_rsp_ready: op_count += 1 (wraps at 2^CNT_W); go IDLE. The other requester's rsp_valid stays 0.
- Latency: accept at edge k → rsp_valid high from cycle k+2. Minimum issue interval is 3 cycles (no new accept in RESP).
- rN_rsp_data/zero are held at their last captured value outside RESP; only rsp_valid qualifies them.
- alu_* outputs hold their last operands outside EXEC, so there is no toggling while idle.
- Requester inputs are sampled only at the accept edge. Later changes while busy have no effect.
- A requester that stays valid while the other is served wins the next IDLE cycle (fairness: at most one op of wait under contention).
- Backpressure: rsp_ready low holds RESP indefinitely; both rN_ready stay 0.
- Reset mid-operation: the in-flight op is discarded, no response is issued, and state returns to IDLE with reset values.
- No arithmetic in this block beyond op_count. The ALU defines result semantics (cs 000/010 add, 110 subtract, 011/001 decode by funct7/funct3).

Test Plan:
- Single op: r0 cs=000, x1=5, x2=7, rsp_ready=1 → r0_ready high in accept cycle; r0_rsp_valid two cycles later with data=12, zero=0; op_count=1; r1_rsp_valid never high.
- Zero flag/subtract: r1 cs=110, x1=x2=0x1234 → r1_rsp_data=0, r1_rsp_zero=1.
- Contention: r0 and r1 both valid continuously after reset → grants alternate 0,1,0,1 (r0: 3+4=7, r1: 6-2=4 via cs=110); each response goes to the correct requester only.
- Backpressure: r0 op cs=011, funct7=0000001, funct3=000, x1=-3, x2=4 with rsp_ready low for 5 cycles → rsp_valid and data=-12 held stable, busy=1, r1_ready=0 throughout; completes when rsp_ready rises.
- Reset mid-op: deassert rst_n during EXEC → immediately rsp_valid=0, busy=0, op_count=0; after release, a fresh r0 op completes normally and r0 wins the tie.
- Input change after accept: change r0_x1 from 1 to 100 during EXEC with cs=000, x2=1 → result 2.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU.
// One operation in flight: accept, execute one cycle, hold the response.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [2:0]       r0_cs,
    input  logic [WIDTH-1:0] r0_x1,
    input  logic [WIDTH-1:0] r0_x2,
    input  logic [6:0]       r0_funct7,
    input  logic [2:0]       r0_funct3,
    output logic             r0_rsp_valid,
    input  logic             r0_rsp_ready,
    output logic [WIDTH-1:0] r0_rsp_data,
    output logic             r0_rsp_zero,

    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [2:0]       r1_cs,
    input  logic [WIDTH-1:0] r1_x1,
    input  logic [WIDTH-1:0] r1_x2,
    input  logic [6:0]       r1_funct7,
    input  logic [2:0]       r1_funct3,
    output logic             r1_rsp_valid,
    input  logic             r1_rsp_ready,
    output logic [WIDTH-1:0] r1_rsp_data,
    output logic             r1_rsp_zero,

    output logic [2:0]       alu_cs,
    output logic [WIDTH-1:0] alu_x1,
    output logic [WIDTH-1:0] alu_x2,
    output logic [6:0]       alu_funct7,
    output logic [2:0]       alu_funct3,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,

    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0]       cs;
        logic [WIDTH-1:0] x1;
        logic [WIDTH-1:0] x2;
        logic [6:0]       funct7;
        logic [2:0]       funct3;
    } op_t;

    state_t           state;
    state_t           state_nxt;
    op_t              op_q;
    op_t              op_sel;
    logic             grant_q;
    logic             last_grant;
    logic [WIDTH-1:0] res_data;
    logic             res_zero;
    logic             win0;
    logic             win1;
    logic             accept;
    logic             rsp_done;

    // Round-robin winner; a tie goes to the requester not served last.
    always_comb begin
        win0 = 1'b0;
        win1 = 1'b0;
        unique case (1'b1)
            r0_valid && r1_valid: begin
                win0 = last_grant;
                win1 = !last_grant;
            end
            r0_valid && !r1_valid: win0 = 1'b1;
            !r0_valid && r1_valid: win1 = 1'b1;
            default: ;
        endcase
    end

    // Handshake decode, operand mux and next state.
    always_comb begin
        state_nxt    = state;
        r0_ready     = 1'b0;
        r1_ready     = 1'b0;
        r0_rsp_valid = 1'b0;
        r1_rsp_valid = 1'b0;
        accept       = 1'b0;
        rsp_done     = 1'b0;
        op_sel       = '{cs: r0_cs, x1: r0_x1, x2: r0_x2,
                         funct7: r0_funct7, funct3: r0_funct3};
        if (win1) begin
            op_sel = '{cs: r1_cs, x1: r1_x1, x2: r1_x2,
                       funct7: r1_funct7, funct3: r1_funct3};
        end
        unique case (state)
            IDLE: begin
                r0_ready = win0;
                r1_ready = win1;
                accept   = win0 || win1;
                if (accept) state_nxt = EXEC;
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                r0_rsp_valid = !grant_q;
                r1_rsp_valid = grant_q;
                rsp_done     = grant_q ? r1_rsp_ready : r0_rsp_ready;
                if (rsp_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Operand and grant capture on accept; held until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= '0;
            grant_q    <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            op_q       <= op_sel;
            grant_q    <= win1;
            last_grant <= win1;
        end
    end

    // Result capture at the end of the single execute cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data <= '0;
            res_zero <= 1'b0;
        end else if (state == EXEC) begin
            res_data <= alu_out;
            res_zero <= alu_zero;
        end
    end

    // Completed-operation counter, bumped on each response handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        op_count <= '0;
        else if (rsp_done) op_count <= op_count + 1'b1;
    end

    assign alu_cs      = op_q.cs;
    assign alu_x1      = op_q.x1;
    assign alu_x2      = op_q.x2;
    assign alu_funct7  = op_q.funct7;
    assign alu_funct3  = op_q.funct3;

    assign r0_rsp_data = res_data;
    assign r0_rsp_zero = res_zero;
    assign r1_rsp_data = res_data;
    assign r1_rsp_zero = res_zero;

    assign busy        = (state != IDLE);

endmodule
